// File: rtl/cvt_dispatch_pkg.sv
// rtl/cvt_dispatch_pkg.sv - shared widths, FSM state and batch record for the batch dispatcher
package cvt_dispatch_pkg;

  localparam int MASK_W = 64;
  localparam int TID_W  = 10;
  localparam int BB_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TID_W-1:0]  base;
    logic [MASK_W-1:0] mask;
    logic [BB_W-1:0]   bb;
  } batch_t;

endpackage

// File: rtl/cvt_batch_dispatcher_if.sv
// rtl/cvt_batch_dispatcher_if.sv - batch intake and thread issue handshake bundle
interface cvt_batch_dispatcher_if #(
  parameter int MASK_W = cvt_dispatch_pkg::MASK_W,
  parameter int TID_W  = cvt_dispatch_pkg::TID_W,
  parameter int BB_W   = cvt_dispatch_pkg::BB_W
);

  logic              send_batch;
  logic [TID_W-1:0]  base_id;
  logic [MASK_W-1:0] bitmap;
  logic [BB_W-1:0]   bb_index;
  logic              batch_ready;

  logic              thr_valid;
  logic              thr_ready;
  logic [TID_W-1:0]  thr_tid;
  logic [BB_W-1:0]   thr_bb;
  logic              thr_last;

  // master is the dispatcher itself; slave is the CVU/CVT plus lane side
  modport master (
    input  send_batch, base_id, bitmap, bb_index, thr_ready,
    output batch_ready, thr_valid, thr_tid, thr_bb, thr_last
  );

  modport slave (
    output send_batch, base_id, bitmap, bb_index, thr_ready,
    input  batch_ready, thr_valid, thr_tid, thr_bb, thr_last
  );

endinterface

// File: rtl/cvt_lsb_encoder.sv
// rtl/cvt_lsb_encoder.sv - find-first-set index and single-bit-remaining flag over a thread mask
module cvt_lsb_encoder #(
  parameter  int MASK_W = cvt_dispatch_pkg::MASK_W,
  localparam int IDX_W  = $clog2(MASK_W)
) (
  input  logic [MASK_W-1:0] mask,
  output logic [IDX_W-1:0]  index,
  output logic              one_hot_remaining
);

  // scan from the top so the lowest set bit is the final assignment
  always_comb begin
    index = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_W'(i);
      end
    end
  end

  assign one_hot_remaining = (mask != '0) && ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/cvt_batch_dispatcher.sv
// rtl/cvt_batch_dispatcher.sv - queues CVU/CVT batches and expands them into thread IDs; CVT_DISPATCH_STATS_EN adds issued_count
module cvt_batch_dispatcher #(
  parameter int MASK_W     = cvt_dispatch_pkg::MASK_W,
  parameter int TID_W      = cvt_dispatch_pkg::TID_W,
  parameter int BB_W       = cvt_dispatch_pkg::BB_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cvt_batch_dispatcher_if.master bus,
  input  logic                   threads_terminated,
  output logic                   overflow,
  output logic                   all_done,
  output logic                   busy
`ifdef CVT_DISPATCH_STATS_EN
  ,
  output logic [15:0]            issued_count
`endif
);

  import cvt_dispatch_pkg::*;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(MASK_W);

  typedef struct packed {
    logic [TID_W-1:0]  base;
    logic [MASK_W-1:0] mask;
    logic [BB_W-1:0]   bb;
  } entry_t;

  entry_t            q_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              q_full;
  logic              term_seen;

  logic              push_req;
  logic              push;
  logic              drop;
  logic              pop;
  logic              hs;

  state_t            state;
  state_t            state_nxt;
  logic [MASK_W-1:0] w_mask;
  logic [TID_W-1:0]  w_base;
  logic [BB_W-1:0]   w_bb;

  logic [IDX_W-1:0]  lsb_idx;
  logic              lsb_last;

  // fullness uses the registered count, so a same-cycle pop never frees a slot
  assign q_full   = (count == CNT_W'(FIFO_DEPTH));
  assign push_req = bus.send_batch && !term_seen && (bus.bitmap != '0);
  assign push     = push_req && !q_full;
  assign drop     = push_req && q_full;
  assign hs       = bus.thr_valid && bus.thr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      term_seen <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= '{base: bus.base_id, mask: bus.bitmap, bb: bus.bb_index};
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      if (threads_terminated) begin
        term_seen <= 1'b1;
      end
    end
  end

  cvt_lsb_encoder #(.MASK_W(MASK_W)) u_lsb (
    .mask              (w_mask),
    .index             (lsb_idx),
    .one_hot_remaining (lsb_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end else if (term_seen) begin
          state_nxt = DONE;
        end
      end
      ISSUE: begin
        if (hs && lsb_last) begin
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // working copy of the head batch; each accepted thread retires its lowest bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_mask <= '0;
      w_base <= '0;
      w_bb   <= '0;
    end else if (pop) begin
      w_mask <= q_mem[rd_ptr].mask;
      w_base <= q_mem[rd_ptr].base;
      w_bb   <= q_mem[rd_ptr].bb;
    end else if (hs) begin
      w_mask <= w_mask & (w_mask - 1'b1);
    end
  end

  assign bus.thr_valid   = (state == ISSUE);
  assign bus.thr_tid     = w_base + TID_W'(lsb_idx);
  assign bus.thr_bb      = w_bb;
  assign bus.thr_last    = (state == ISSUE) && lsb_last;
  assign bus.batch_ready = !q_full;
  assign busy            = (count != '0) || (state == ISSUE);
  assign all_done        = (state == DONE);

`ifdef CVT_DISPATCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_count <= '0;
    end else if (hs && (issued_count != 16'hFFFF)) begin
      issued_count <= issued_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cvt_batch_dispatcher.sv
// tb/tb_cvt_batch_dispatcher.sv - self-checking bench for cvt_batch_dispatcher against a thread-stream model
module tb_cvt_batch_dispatcher;
  import cvt_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic threads_terminated;
  logic overflow;
  logic all_done;
  logic busy;
`ifdef CVT_DISPATCH_STATS_EN
  logic [15:0] issued_count;
`endif

  cvt_batch_dispatcher_if #(.MASK_W(MASK_W), .TID_W(TID_W), .BB_W(BB_W)) bus ();

  cvt_batch_dispatcher #(.MASK_W(MASK_W), .TID_W(TID_W), .BB_W(BB_W), .FIFO_DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .threads_terminated (threads_terminated),
    .overflow           (overflow),
    .all_done           (all_done),
    .busy               (busy)
`ifdef CVT_DISPATCH_STATS_EN
    ,
    .issued_count       (issued_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int tid;
    int bb;
    bit last;
  } thr_t;

  thr_t exp_q[$];
  int   log_tid[$];
  int   log_cyc[$];
  bit   log_last[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  bit         stall_prev = 1'b0;
  logic [9:0] prev_tid;
  logic [4:0] prev_bb;
  logic       prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // expected thread stream: every set bit in ascending order, tid wraps mod 1024
  function automatic void push_batch(input int base, input logic [63:0] bm, input int bb);
    int hi;
    hi = -1;
    for (int i = 0; i < 64; i++) if (bm[i]) hi = i;
    for (int i = 0; i < 64; i++) begin
      if (bm[i]) begin
        thr_t t;
        t.tid  = (base + i) % 1024;
        t.bb   = bb;
        t.last = (i == hi);
        exp_q.push_back(t);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", bus.thr_valid, 1);
        check("hold_tid", bus.thr_tid, prev_tid);
        check("hold_bb", bus.thr_bb, prev_bb);
        check("hold_last", bus.thr_last, prev_last);
      end
      if (bus.thr_valid && bus.thr_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_thread: got tid %0d, expected no thread", bus.thr_tid);
        end else begin
          thr_t e;
          e = exp_q.pop_front();
          check("thr_tid", bus.thr_tid, e.tid);
          check("thr_bb", bus.thr_bb, e.bb);
          check("thr_last", bus.thr_last, e.last);
        end
        log_tid.push_back(int'(bus.thr_tid));
        log_cyc.push_back(cyc);
        log_last.push_back(bus.thr_last);
      end
      stall_prev = bus.thr_valid && !bus.thr_ready;
      prev_tid   = bus.thr_tid;
      prev_bb    = bus.thr_bb;
      prev_last  = bus.thr_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int base, input logic [63:0] bm, input int bb, input bit accept);
    bus.send_batch = 1'b1;
    bus.base_id    = base[9:0];
    bus.bitmap     = bm;
    bus.bb_index   = bb[4:0];
    if (accept) push_batch(base, bm, bb);
    step();
    bus.send_batch = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.thr_valid && n < 20) begin
      step();
      n++;
    end
    check("wait_valid", bus.thr_valid, 1);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((busy || bus.thr_valid) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_busy", busy, 0);
  endtask

  task automatic clear_log();
    log_tid.delete();
    log_cyc.delete();
    log_last.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst                = 1'b1;
    threads_terminated = 1'b0;
    bus.send_batch     = 1'b0;
    bus.base_id        = '0;
    bus.bitmap         = '0;
    bus.bb_index       = '0;
    bus.thr_ready      = 1'b0;
    repeat (2) step();
    check("rst_valid", bus.thr_valid, 0);
    check("rst_batch_ready", bus.batch_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // basic expansion with latency pinned at N+2
    clear_log();
    bus.thr_ready = 1'b1;
    send(100, 64'h8000_0000_0000_0005, 3, 1);
    @(negedge clk);
    check("lat_n1_valid", bus.thr_valid, 0);
    @(negedge clk);
    check("lat_n2_valid", bus.thr_valid, 1);
    check("lat_n2_tid", bus.thr_tid, 100);
    step();
    wait_drain(20);
    check("basic_count", log_tid.size(), 3);
    if (log_tid.size() == 3) begin
      check("basic_tid0", log_tid[0], 100);
      check("basic_tid1", log_tid[1], 102);
      check("basic_tid2", log_tid[2], 163);
      check("basic_gap", log_cyc[2] - log_cyc[0], 2);
      check("basic_last", {log_last[0], log_last[1], log_last[2]}, 3'b001);
    end

    // backpressure on the second thread
    clear_log();
    bus.thr_ready = 1'b1;
    send(100, 64'h8000_0000_0000_0005, 3, 1);
    step();
    step();
    bus.thr_ready = 1'b0;
    repeat (3) step();
    check("bp_held_tid", bus.thr_tid, 102);
    bus.thr_ready = 1'b1;
    wait_drain(20);
    check("bp_count", log_tid.size(), 3);
    if (log_tid.size() == 3) begin
      check("bp_tid1", log_tid[1], 102);
      check("bp_stall_gap", log_cyc[1] - log_cyc[0], 4);
      check("bp_tid2", log_tid[2], 163);
      check("bp_next_gap", log_cyc[2] - log_cyc[1], 1);
    end

    // thread ID wraps modulo 1024
    clear_log();
    send(1020, 64'h21, 7, 1);
    wait_drain(20);
    check("wrap_count", log_tid.size(), 2);
    if (log_tid.size() == 2) begin
      check("wrap_tid0", log_tid[0], 1020);
      check("wrap_tid1", log_tid[1], 1);
    end

    // zero bitmap is silently discarded
    clear_log();
    send(50, 64'h0, 2, 0);
    repeat (4) step();
    check("zero_overflow", overflow, 0);
    check("zero_busy", busy, 0);
    check("zero_no_thread", log_tid.size(), 0);

    // overflow: one in working regs, four queued, sixth dropped
    clear_log();
    bus.thr_ready = 1'b0;
    send(200, 64'h1, 1, 1);
    send(210, 64'h2, 2, 1);
    send(220, 64'h4, 3, 1);
    send(230, 64'h8, 4, 1);
    send(240, 64'h10, 5, 1);
    send(250, 64'h20, 6, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_batch_ready", bus.batch_ready, 0);
    send(260, 64'h0, 7, 0);
    check("ovf_sticky", overflow, 1);
    bus.thr_ready = 1'b1;
    wait_drain(60);
    check("ovf_threads", log_tid.size(), 5);
    check("ovf_ready_back", bus.batch_ready, 1);

    // asynchronous reset mid-ISSUE
    bus.thr_ready = 1'b0;
    send(300, 64'hFF, 4, 1);
    wait_valid();
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_valid", bus.thr_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_overflow", overflow, 0);
    check("arst_all_done", all_done, 0);
    check("arst_batch_ready", bus.batch_ready, 1);
`ifdef CVT_DISPATCH_STATS_EN
    check("arst_issued", issued_count, 0);
`endif
    step();
    step();
    rst = 1'b0;
    step();

    // termination during the last batch
    clear_log();
    send(5, 64'h3, 1, 1);
    wait_valid();
    threads_terminated = 1'b1;
    step();
    threads_terminated = 1'b0;
    check("term_pending", all_done, 0);
    bus.thr_ready = 1'b1;
    step();
    check("term_mid", all_done, 0);
    step();
    check("term_idle", all_done, 0);
    check("term_idle_valid", bus.thr_valid, 0);
    step();
    check("term_done", all_done, 1);
    send(500, 64'h1, 2, 0);
    repeat (5) step();
    check("term_sticky", all_done, 1);
    check("term_ignore_valid", bus.thr_valid, 0);
    check("term_ignore_busy", busy, 0);
    check("term_threads", log_tid.size(), 2);
`ifdef CVT_DISPATCH_STATS_EN
    check("term_issued", issued_count, 2);
`endif
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cvt_batch_dispatcher.md
Name: cvt_batch_dispatcher

Overview:
Downstream stage of the CVU/CVT convergence unit. Consumes the batch that unit emits: a send_batch pulse with baseID, a 64-bit active-thread bitmap and a BB index. Queues each batch, then expands it into one CUDA thread ID per cycle for the execution lanes over a valid/ready handshake. Tracks the threads_terminated event and signals global completion once all queued work has drained.

Parameters:
MASK_W, 64, bitmap width (threads per batch)
TID_W, 10, thread ID / baseID width
BB_W, 5, basic-block index width
FIFO_DEPTH, 4, batch queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
send_batch  in  1  single-cycle batch strobe from CVU/CVT
base_id  in  TID_W  baseID_read_from_CVT
bitmap  in  MASK_W  bitmap_read_from_CVT
bb_index  in  BB_W  BB_index_out
threads_terminated  in  1  program-end indication
batch_ready  out  1  queue not full
thr_valid  out  1  thread ID valid
thr_ready  in  1  lane accepts thread
thr_tid  out  TID_W  issued CUDA thread ID
thr_bb  out  BB_W  BB index of issued thread
thr_last  out  1  final active thread of current batch
overflow  out  1  sticky: batch dropped
all_done  out  1  all work drained after termination
busy  out  1  queue non-empty or issuing

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high. Every register clears on rst: all outputs 0 except batch_ready=1. Queue is empty, FSM is in IDLE, sticky flags are cleared. Reset mid-batch discards the in-flight batch and all queued batches.
- Enqueue happens when send_batch=1, term_seen=0 and bitmap!=0:
  - Queue not full: push {base_id, bitmap, bb_index}.
  - Queue full: drop the batch and set overflow (sticky until reset).
  - No bypass. Fullness is evaluated on the registered count before that cycle's pop.
- bitmap==0 batches are discarded silently; overflow is not set.
- send_batch while term_seen=1 is ignored.
- threads_terminated sets sticky term_seen.
- FSM states are IDLE, ISSUE, DONE:
  - IDLE: if queue non-empty, pop head into working regs (mask, base, bb), go to ISSUE. Else if term_seen, go to DONE.
  - ISSUE:
    - thr_valid=1.
    - thr_tid = base + index of lowest set bit of mask, modulo 2^TID_W (wraps).
    - thr_bb = bb.
    - thr_last = 1 when mask has exactly one bit set.
    - On thr_valid&&thr_ready, clear the lowest bit. On the last handshake, go back to IDLE.
    - No back-to-back reload: there is a 1-cycle bubble between batches.
  - DONE: absorbing until reset. all_done = (state==DONE).
- Outputs are registered or derived from registered state. While thr_valid=1 and thr_ready=0, thr_tid, thr_bb and thr_last hold stable.
- Latency: send_batch at cycle N into an empty queue with FSM in IDLE gives thr_valid=1 at N+2. Throughput is 1 thread per cycle within a batch.
- busy = (count!=0) || (state==ISSUE).
- Simultaneous push and pop in the same cycle: count unchanged.

Optional Feature:
CVT_DISPATCH_STATS_EN:
- Defined: adds output issued_count [15:0]. It increments on each thr_valid&&thr_ready handshake, saturates at 16'hFFFF, and clears on rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cvt_dispatch_pkg:
  - width constants MASK_W, TID_W, BB_W defaults;
  - state enum {IDLE, ISSUE, DONE};
  - packed struct batch_t {base, mask, bb}.
- One sub-module, cvt_lsb_encoder: combinational find-first-set over MASK_W. It outputs index [$clog2(MASK_W)-1:0] and a one_hot_remaining flag (popcount==1) for thr_last.
- The queue is an internal circular buffer with a count register.

Test Plan:
- Reset: assert rst asynchronously mid-ISSUE -> thr_valid=0, busy=0, overflow=0, all_done=0, batch_ready=1 immediately.
- Basic expansion: base_id=100, bitmap=64'h8000_0000_0000_0005, bb_index=3, thr_ready=1 -> thr_tid 100, 102, 163 on consecutive cycles from N+2; thr_bb=3 on each; thr_last only on 163.
- Backpressure: same batch, thr_ready=0 for 3 cycles on the 2nd thread -> thr_tid=102 held stable; 163 follows the cycle after ready returns.
- Wrap: base_id=1020, bitmap bits {0,5} -> thr_tid 1020 then 1 (1025 mod 1024).
- Overflow: six back-to-back send_batch with non-zero bitmaps and thr_ready=0 -> five accepted (one in working regs, four queued), sixth dropped, overflow=1, batch_ready=0; a zero-bitmap send leaves overflow unchanged.
- Termination: threads_terminated during ISSUE of a 2-thread batch, queue empty -> all_done=0 until the final handshake; all_done=1 two cycles later (IDLE then DONE) and stays 1; later send_batch ignored; with CVT_DISPATCH_STATS_EN, issued_count=2.
